uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Serial receive front end for the CPU's UART path. It consumes the already-synchronized RX line (output of the board-level 2-FF synchronizer) and deframes 8N1 characters with a mid-bit sampling state machine. Received bytes are buffered in a small first-word-fall-through FIFO with a valid/ready interface toward the CPU's UART peripheral registers. Framing errors and overflows are reported as single-cycle strobes.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 217: clock cycles per bit (25 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, default 4: FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_rx`  in  1  synchronized serial input; idle high.
- `o_data`  out  8  byte at the FIFO head.
- `o_valid`  out  1  FIFO not empty.
- `i_ready`  in  1  consumer accepts the head byte when `o_valid & i_ready`.
- `o_frame_err`  out  1  one-cycle strobe: stop bit sampled low.
- `o_overflow`  out  1  one-cycle strobe: good byte dropped because the FIFO was full.

## Operation
- Decided: one clock; reset is asynchronous, active-low, on `i_rst_n`.
- Reset values:
  - `o_valid`=0, `o_data`=0x00, `o_frame_err`=0, `o_overflow`=0.
  - FSM is in IDLE; FIFO pointers, count, storage and bit counter are all 0.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- Baud counter: width `$clog2(CLKS_PER_BIT)`. It is reloaded on every state entry.
- IDLE:
  - If `i_rx`=0, go to START and load the counter for `CLKS_PER_BIT/2` (integer division).
- START: when the half-bit count expires, sample `i_rx`.
  - If 0, go to DATA with the bit index at 0.
  - If 1, treat it as a glitch and return to IDLE. No strobe is raised.
- DATA:
  - Every `CLKS_PER_BIT` cycles, sample `i_rx` into the shift register, LSB first.
  - After bit index 7 is sampled, go to STOP.
- STOP: after `CLKS_PER_BIT` cycles, sample `i_rx`.
  - If 1, push the byte and return to IDLE.
  - If 0, pulse `o_frame_err`, discard the byte and go to BREAK.
- BREAK: stay until `i_rx`=1, then go to IDLE. This prevents a held-low line from producing repeated errors.
- FIFO:
  - Count width is `$clog2(FIFO_DEPTH)+1`. Pointers wrap modulo `FIFO_DEPTH`.
  - `o_data` equals the storage entry at the read pointer. It is held stable while `o_valid` is high and `i_ready` is low.
  - Pop happens when `o_valid & i_ready`.
  - Push happens on a good stop bit when `count < FIFO_DEPTH`, or when the FIFO is full and a pop occurs in the same cycle.
  - Push when full without a pop: drop the byte, pulse `o_overflow`, and leave FIFO contents unchanged.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - `i_ready` while empty has no effect.
- Reset mid-frame: reset aborts immediately. The next frame is recognized only after a fresh falling edge in IDLE.

## Timing
- Let cycle t be the first cycle `i_rx`=0 is observed in IDLE.
- Start sample: t + `CLKS_PER_BIT/2`.
- Data bit k sample: t + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`.
- Stop sample: t + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- Cycle after the stop sample:
  - `o_valid` rises, if the FIFO was empty.
  - `o_frame_err` or `o_overflow` is high for exactly that one cycle, when applicable.
- After a good stop, IDLE is entered at the stop sample + 1. A start bit arriving at or after that cycle is detected, so back-to-back frames are supported.
- Pop: `o_valid`/`o_data` update the cycle after the accepting edge. There is no combinational path from `i_ready` to the outputs.

## Test plan
Use `CLKS_PER_BIT`=8, `FIFO_DEPTH`=4 for all scenarios.
- **Single byte:** send 0xA5, 8N1, with `i_ready`=0.
  - `o_valid`=1 and `o_data`=0xA5 at t+77.
  - Then assert `i_ready` for 1 cycle → `o_valid`=0 on the next cycle.
- **Glitch rejection:** drive `i_rx` low for 3 cycles, then high → no `o_valid`, no strobes, FSM returns to IDLE.
- **Framing error:** send 0x3C with stop bit 0, then hold `i_rx` low for 40 cycles.
  - Exactly one `o_frame_err` pulse.
  - No push.
  - Next valid frame 0x11 is received correctly.
- **Overflow:** send 5 back-to-back bytes 0x01–0x05 with `i_ready`=0.
  - FIFO holds 0x01–0x04.
  - One `o_overflow` pulse after the 5th stop bit.
  - Draining yields 0x01, 0x02, 0x03, 0x04 in order.
- **Simultaneous push/pop when full:** fill with 0x10–0x13, then hold `i_ready`=1 on the exact cycle 0x14 is pushed.
  - No overflow.
  - Draining yields 0x11, 0x12, 0x13, 0x14.
- **Async reset mid-frame:** pulse `i_rst_n` low during data bit 4 of 0xFF.
  - All outputs are 0 immediately (before the next edge).
  - The partial byte is never delivered.
  - A following 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, feeding a first-word-fall-through FIFO.
// Framing errors and overflow drops are reported as single-cycle strobes.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overflow
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    // Loads are one less than the interval because the sample happens on the zero count.
    localparam logic [BAUD_W-1:0] HALF_LOAD = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BIT_LOAD  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t            state, state_next;
    logic [BAUD_W-1:0] baud_cnt, baud_next;
    logic [2:0]        bit_idx, bit_next;
    logic [7:0]        shift_reg, shift_next;
    logic              baud_done;
    logic              push_req;
    logic              frame_err_next;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              push;
    logic              pop;

    assign baud_done = (baud_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next     = state;
        baud_next      = baud_cnt;
        bit_next       = bit_idx;
        shift_next     = shift_reg;
        push_req       = 1'b0;
        frame_err_next = 1'b0;
        case (state)
            S_IDLE: begin
                if (!i_rx) begin
                    state_next = S_START;
                    baud_next  = HALF_LOAD;
                end
            end
            S_START: begin
                if (!baud_done) begin
                    baud_next = baud_cnt - BAUD_W'(1);
                end else if (!i_rx) begin
                    state_next = S_DATA;
                    baud_next  = BIT_LOAD;
                    bit_next   = '0;
                end else begin
                    state_next = S_IDLE;
                    baud_next  = BIT_LOAD;
                end
            end
            S_DATA: begin
                if (!baud_done) begin
                    baud_next = baud_cnt - BAUD_W'(1);
                end else begin
                    shift_next = {i_rx, shift_reg[7:1]};
                    baud_next  = BIT_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (!baud_done) begin
                    baud_next = baud_cnt - BAUD_W'(1);
                end else begin
                    baud_next = BIT_LOAD;
                    if (i_rx) begin
                        push_req   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Wait out a held-low line so it cannot retrigger a frame.
                if (i_rx) begin
                    state_next = S_IDLE;
                    baud_next  = BIT_LOAD;
                end
            end
            default: begin
                state_next = S_IDLE;
                baud_next  = BIT_LOAD;
            end
        endcase
    end

    assign full    = (count == DEPTH_C);
    assign o_valid = (count != '0);
    assign o_data  = mem[rd_ptr];
    assign pop     = o_valid & i_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push    = push_req & (~full | pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_frame_err <= 1'b0;
            o_overflow  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            o_frame_err <= frame_err_next;
            o_overflow  <= push_req & full & ~pop;
            if (push) begin
                mem[wr_ptr] <= shift_reg;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with CLKS_PER_BIT=8, FIFO_DEPTH=4.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overflow;

    int tests = 0;
    int fails = 0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;
    int base_f;
    int base_o;
    logic pre_v;

    uart_rx_fifo #(
        .CLKS_PER_BIT(8),
        .FIFO_DEPTH  (4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx       (rx),
        .o_data     (data),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_frame_err(frame_err),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (overflow) ovf_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives start, 8 data bits and 5 cycles of the stop bit; returns one cycle after the stop sample.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_at_stop,
                              output logic v_before);
        rx = 1'b0;
        repeat (8) tick();
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (8) tick();
        end
        rx = stop;
        repeat (4) tick();
        v_before = valid;
        if (pop_at_stop) ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        rx    = 1'b1;
        ready = 1'b0;
        #2 rst_n = 1'b0;
        idle(2);
        check("rst_valid", {15'd0, valid}, 16'h0);
        check("rst_data", {8'd0, data}, 16'h00);
        check("rst_ferr", {15'd0, frame_err}, 16'h0);
        check("rst_ovf", {15'd0, overflow}, 16'h0);
        rst_n = 1'b1;
        idle(4);

        // Single byte, latency t+77
        send_frame(8'hA5, 1'b1, 1'b0, pre_v);
        check("single_valid_t76", {15'd0, pre_v}, 16'h0);
        check("single_valid_t77", {15'd0, valid}, 16'h1);
        check("single_data", {8'd0, data}, 16'hA5);
        idle(3);
        check("single_hold", {8'd0, data}, 16'hA5);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("single_pop", {15'd0, valid}, 16'h0);

        // Glitch rejection
        base_f = ferr_cnt;
        base_o = ovf_cnt;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(100);
        check("glitch_valid", {15'd0, valid}, 16'h0);
        check("glitch_ferr", 16'(ferr_cnt - base_f), 16'h0);
        check("glitch_ovf", 16'(ovf_cnt - base_o), 16'h0);

        // Framing error followed by held-low line
        send_frame(8'h3C, 1'b0, 1'b0, pre_v);
        check("ferr_strobe", {15'd0, frame_err}, 16'h1);
        check("ferr_nopush", {15'd0, valid}, 16'h0);
        idle(40);
        check("ferr_once", 16'(ferr_cnt - base_f), 16'h1);
        check("ferr_nopush_late", {15'd0, valid}, 16'h0);
        rx = 1'b1;
        idle(10);
        send_frame(8'h11, 1'b1, 1'b0, pre_v);
        idle(3);
        check("after_ferr_valid", {15'd0, valid}, 16'h1);
        check("after_ferr_data", {8'd0, data}, 16'h11);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("after_ferr_pop", {15'd0, valid}, 16'h0);

        // Overflow on 5th back-to-back byte
        base_o = ovf_cnt;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, pre_v);
            if (i == 5) check("ovf_strobe", {15'd0, overflow}, 16'h1);
            idle(3);
        end
        check("ovf_once", 16'(ovf_cnt - base_o), 16'h1);
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_drain%0d", i), {8'd0, data}, 16'(i));
            tick();
        end
        ready = 1'b0;
        check("ovf_empty", {15'd0, valid}, 16'h0);

        // Push and pop in the same cycle while full
        base_o = ovf_cnt;
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1, 1'b0, pre_v);
            idle(3);
        end
        send_frame(8'h14, 1'b1, 1'b1, pre_v);
        check("pp_no_ovf", {15'd0, overflow}, 16'h0);
        idle(3);
        check("pp_no_ovf_cnt", 16'(ovf_cnt - base_o), 16'h0);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pp_drain%0d", i), {8'd0, data}, 16'h11 + 16'(i));
            tick();
        end
        ready = 1'b0;
        check("pp_empty", {15'd0, valid}, 16'h0);

        // Asynchronous reset during data bit 4 of 0xFF, with a byte already buffered
        send_frame(8'h77, 1'b1, 1'b0, pre_v);
        idle(3);
        check("pre_rst_valid", {15'd0, valid}, 16'h1);
        rx = 1'b0;
        idle(8);
        rx = 1'b1;
        idle(35);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {15'd0, valid}, 16'h0);
        check("arst_data", {8'd0, data}, 16'h00);
        check("arst_ferr", {15'd0, frame_err}, 16'h0);
        check("arst_ovf", {15'd0, overflow}, 16'h0);
        tick();
        rst_n = 1'b1;
        idle(40);
        check("arst_no_partial", {15'd0, valid}, 16'h0);
        send_frame(8'h5A, 1'b1, 1'b0, pre_v);
        check("arst_next_valid", {15'd0, valid}, 16'h1);
        check("arst_next_data", {8'd0, data}, 16'h5A);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
